// File: rtl/traffic_sequencer.sv
// Highway/country-road traffic light sequencer with optional pedestrian walk phase.
// Define TRAFFIC_PED_EN to build the pedestrian logic (ped_pending, PW state, walk lamp).
module traffic_sequencer #(
  parameter int HG_MIN   = 6,
  parameter int Y_TIME   = 3,
  parameter int CG_MAX   = 4,
  parameter int PED_TIME = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car_sensor,
  input  logic       ped_req,
  output logic [2:0] state,
  output logic [3:0] counter,
  output logic       H_R,
  output logic       H_Y,
  output logic       H_G,
  output logic       C_R,
  output logic       C_Y,
  output logic       C_G,
  output logic       walk
);

  localparam logic [2:0] S_HG = 3'b000;
  localparam logic [2:0] S_HY = 3'b001;
  localparam logic [2:0] S_CG = 3'b010;
  localparam logic [2:0] S_CY = 3'b011;
  localparam logic [2:0] S_PW = 3'b100;

  // Last counter value of each timed phase.
  localparam logic [3:0] HG_LAST  = 4'(HG_MIN - 1);
  localparam logic [3:0] Y_LAST   = 4'(Y_TIME - 1);
  localparam logic [3:0] CG_LAST  = 4'(CG_MAX - 1);
  localparam logic [3:0] PED_LAST = 4'(PED_TIME - 1);

  logic [2:0] state_reg, state_next;
  logic [3:0] counter_reg, counter_next;
  logic       ped_pending;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_HG: if (counter_reg >= HG_LAST && (car_sensor || ped_pending)) state_next = S_HY;
      S_HY: if (counter_reg == Y_LAST) state_next = ped_pending ? S_PW : S_CG;
      S_CG: if (counter_reg == CG_LAST || !car_sensor) state_next = S_CY;
      S_CY: if (counter_reg == Y_LAST) state_next = S_HG;
      S_PW: if (counter_reg == PED_LAST) state_next = S_HG;
      default: state_next = S_HG;
    endcase
  end

  // Any state change (including recovery from an illegal code) restarts the count.
  always_comb begin
    counter_next = counter_reg + 4'd1;
    if (state_next != state_reg)
      counter_next = 4'd0;
    else if (state_reg == S_HG && counter_reg == 4'hF)
      counter_next = 4'hF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_HG;
      counter_reg <= 4'd0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
    end
  end

`ifdef TRAFFIC_PED_EN
  logic ped_pending_reg, ped_pending_next;

  // Entering PW clears the request even if the button is pressed on the same edge.
  always_comb begin
    ped_pending_next = ped_pending_reg;
    if (state_next == S_PW && state_reg != S_PW)
      ped_pending_next = 1'b0;
    else if (ped_req && state_reg != S_PW)
      ped_pending_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) ped_pending_reg <= 1'b0;
    else       ped_pending_reg <= ped_pending_next;
  end

  assign ped_pending = ped_pending_reg;
  assign walk        = (state_reg == S_PW);
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
  assign ped_pending    = 1'b0;
  assign walk           = 1'b0;
`endif

  always_comb begin
    H_R = 1'b0; H_Y = 1'b0; H_G = 1'b0;
    C_R = 1'b0; C_Y = 1'b0; C_G = 1'b0;
    case (state_reg)
      S_HG:    begin H_G = 1'b1; C_R = 1'b1; end
      S_HY:    begin H_Y = 1'b1; C_R = 1'b1; end
      S_CG:    begin H_R = 1'b1; C_G = 1'b1; end
      S_CY:    begin H_R = 1'b1; C_Y = 1'b1; end
      S_PW:    begin H_R = 1'b1; C_R = 1'b1; end
      default: ;
    endcase
  end

  assign state   = state_reg;
  assign counter = counter_reg;

endmodule

// File: tb/tb_traffic_sequencer.sv
// Self-checking bench for traffic_sequencer: directed scenarios plus random traffic,
// compared each cycle against a phase/age reference model (honours TRAFFIC_PED_EN).
module tb_traffic_sequencer;

  localparam int HG_MIN   = 6;
  localparam int Y_TIME   = 3;
  localparam int CG_MAX   = 4;
  localparam int PED_TIME = 5;
`ifdef TRAFFIC_PED_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  localparam int P_HG = 0, P_HY = 1, P_CG = 2, P_CY = 3, P_PW = 4;

  logic       clk = 1'b0;
  logic       reset, car_sensor, ped_req;
  logic [2:0] state;
  logic [3:0] counter;
  logic       H_R, H_Y, H_G, C_R, C_Y, C_G, walk;

  traffic_sequencer #(
    .HG_MIN(HG_MIN), .Y_TIME(Y_TIME), .CG_MAX(CG_MAX), .PED_TIME(PED_TIME)
  ) dut (
    .clk(clk), .reset(reset), .car_sensor(car_sensor), .ped_req(ped_req),
    .state(state), .counter(counter),
    .H_R(H_R), .H_Y(H_Y), .H_G(H_G), .C_R(C_R), .C_Y(C_Y), .C_G(C_G),
    .walk(walk)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: which phase we are in, how long we have been there, pending button.
  int m_phase = P_HG;
  int m_age   = 0;
  bit m_pend  = 1'b0;
  logic [6:0] lamp_tab [5];   // {H_R,H_Y,H_G,C_R,C_Y,C_G,walk}
  int walk_cnt;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic car, input logic ped);
    int nxt;
    if (r) begin
      m_phase = P_HG; m_age = 0; m_pend = 1'b0;
      return;
    end
    nxt = m_phase;
    if (m_phase == P_HG && m_age >= HG_MIN - 1 && (car || m_pend)) nxt = P_HY;
    if (m_phase == P_HY && m_age == Y_TIME - 1)                    nxt = m_pend ? P_PW : P_CG;
    if (m_phase == P_CG && (m_age == CG_MAX - 1 || !car))          nxt = P_CY;
    if (m_phase == P_CY && m_age == Y_TIME - 1)                    nxt = P_HG;
    if (m_phase == P_PW && m_age == PED_TIME - 1)                  nxt = P_HG;
    if (nxt == P_PW) m_pend = 1'b0;
    else if (PED_EN && ped && m_phase != P_PW) m_pend = 1'b1;
    m_age   = (nxt != m_phase) ? 0 : m_age + 1;
    m_phase = nxt;
  endtask

  task automatic step(input logic r, input logic car, input logic ped);
    @(negedge clk);
    reset = r; car_sensor = car; ped_req = ped;
    @(posedge clk);
    model_edge(r, car, ped);
    #1;
    check("state", {5'd0, state}, 8'(m_phase));
    check("counter", {4'd0, counter}, 8'((m_age > 15) ? 15 : m_age));
    check("lamps", {1'b0, H_R, H_Y, H_G, C_R, C_Y, C_G, walk}, {1'b0, lamp_tab[m_phase]});
    if (walk) walk_cnt++;
  endtask

  initial begin
    bit ped_done;
    reset = 1'b1; car_sensor = 1'b0; ped_req = 1'b0;
    lamp_tab[P_HG] = 7'b0011000;
    lamp_tab[P_HY] = 7'b0101000;
    lamp_tab[P_CG] = 7'b1000010;
    lamp_tab[P_CY] = 7'b1000100;
    lamp_tab[P_PW] = 7'b1001001;
    walk_cnt = 0;

    // Continuous country traffic: 16-cycle cycle, back at HG counter 0 after each period.
    step(1, 0, 0); step(1, 0, 0);
    check("reset_state", {5'd0, state}, 8'd0);
    check("reset_lamps", {1'b0, H_R, H_Y, H_G, C_R, C_Y, C_G, walk}, 8'b00011000);
    repeat (16) step(0, 1, 0);
    check("period16", {1'b0, state, counter}, 8'h00);
    repeat (16) step(0, 1, 0);
    check("period32", {1'b0, state, counter}, 8'h00);

    // Idle highway: counter saturates at 15.
    step(1, 0, 0);
    repeat (40) step(0, 0, 0);
    check("hg_saturate", {1'b0, state, counter}, 8'h0F);

    // Car leaves early in CG.
    step(1, 0, 0);
    for (int i = 0; i < 40 && !(m_phase == P_CG && m_age == 1); i++) step(0, 1, 0);
    check("reach_cg1", {1'b0, state, counter}, 8'h21);
    step(0, 0, 0);
    check("cg_early_exit", {1'b0, state, counter}, 8'h30);
    repeat (3) step(0, 0, 0);
    check("cy_to_hg", {1'b0, state, counter}, 8'h00);

    // Lone pedestrian press at HG counter 2.
    step(1, 0, 0);
    step(0, 0, 0); step(0, 0, 0);
    step(0, 0, 1);
    walk_cnt = 0;
    repeat (20) step(0, 0, 0);
    check("walk_cycles", 8'(walk_cnt), PED_EN ? 8'd5 : 8'd0);

    // Pedestrian plus car together; a second press during PW must be ignored.
    step(1, 0, 0);
    step(0, 1, 1);
    ped_done = 1'b0;
    walk_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_phase == P_PW && !ped_done) begin
        step(0, 1, 1);
        ped_done = 1'b1;
      end else begin
        step(0, 1, 0);
      end
    end
    check("single_pw", 8'(walk_cnt), PED_EN ? 8'd5 : 8'd0);

    // Reset in the middle of CG.
    step(1, 0, 0);
    step(0, 0, 1);
    for (int i = 0; i < 60 && !(m_phase == P_CG && m_age == 2); i++) step(0, 1, 0);
    check("reach_cg2", {1'b0, state, counter}, 8'h22);
    step(1, 1, 0);
    check("mid_cg_reset", {1'b0, state, counter}, 8'h00);
    check("mid_cg_lamps", {1'b0, H_R, H_Y, H_G, C_R, C_Y, C_G, walk}, 8'b00011000);
    repeat (10) step(0, 0, 0);

    // Random traffic with occasional buttons and resets.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 14) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_sequencer.md
TRAFFIC_SEQUENCER -- requirements
Module: traffic_sequencer

Interface
REQ-001 Parameter HG_MIN, default 6: minimum highway-green cycles; legal range 1..15.
REQ-002 Parameter Y_TIME, default 3: yellow duration in cycles, both roads; legal range 1..15.
REQ-003 Parameter CG_MAX, default 4: maximum country-green cycles; legal range 1..15.
REQ-004 Parameter PED_TIME, default 5: pedestrian-walk duration in cycles; legal range 1..15.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 car_sensor  input  1  country-road vehicle present; level, sampled each edge.
REQ-008 ped_req  input  1  pedestrian button; a single-cycle pulse is sufficient.
REQ-009 state  output  3  current state: HG=000, HY=001, CG=010, CY=011, PW=100.
REQ-010 counter  output  4  cycles spent in the current state, starting at 0.
REQ-011 H_R, H_Y, H_G, C_R, C_Y, C_G  output  1 each  highway and country lamp drives.
REQ-012 walk  output  1  pedestrian walk lamp.

Function
REQ-013 Moore FSM; lamp outputs SHALL be decoded from the state register only, never from inputs.
REQ-014 Lamp decode SHALL be:
- HG: H_G, C_R.
- HY: H_Y, C_R.
- CG: H_R, C_G.
- CY: H_R, C_Y.
- PW: H_R, C_R, walk.
- All other lamps 0.
REQ-015 counter SHALL clear to 0 on the edge that changes state and otherwise increment by 1.
REQ-016 In HG, counter SHALL saturate at 15 rather than wrap.
REQ-017 HG->HY SHALL occur when counter >= HG_MIN-1 and (car_sensor=1 or ped_pending=1).
REQ-018 With no pending request, the FSM SHALL stay in HG indefinitely.
REQ-019 HY SHALL last exactly Y_TIME cycles, then go to PW if ped_pending=1, else to CG.
REQ-020 Pedestrian service SHALL win when both requests are pending at the end of HY.
REQ-021 CG->CY SHALL occur when counter = CG_MAX-1 or car_sensor=0; CG therefore lasts at least 1 cycle.
REQ-022 CY SHALL last exactly Y_TIME cycles, then go to HG.
REQ-023 PW SHALL last exactly PED_TIME cycles, then go to HG.
REQ-024 Internal flag ped_pending SHALL set on any edge where ped_req=1 and the FSM is not in, or entering, PW.
REQ-025 ped_pending SHALL clear on the edge that enters PW; clear wins over a simultaneous ped_req.
REQ-026 ped_req asserted while in PW SHALL be ignored.
REQ-027 Unused state encodings (101..111) SHALL recover to HG with counter=0 on the next edge.

Reset
REQ-028 While reset=1 at a clock edge, the following SHALL apply regardless of current state, including mid-CG, mid-PW and yellow states:
- state=HG, counter=0, ped_pending=0.
- Lamps H_G=1, C_R=1, all other lamps 0, walk=0.
REQ-029 reset SHALL take priority over every transition.
REQ-030 The first state advance after reset SHALL follow the normal HG rules starting from counter=0.

Configuration
REQ-031 Macro TRAFFIC_PED_EN defined: pedestrian logic (ped_pending, PW state, walk) SHALL be present exactly as specified above.
REQ-032 Macro TRAFFIC_PED_EN undefined: ped_req SHALL be ignored, walk SHALL be constant 0, PW SHALL be unreachable, and HY SHALL always exit to CG.

Verification (default parameters; TRAFFIC_PED_EN defined unless stated)
REQ-033 reset 2 cycles, then car_sensor=1 held -> 16-cycle repeating period:
- HG counter 0..5, HY 3 cycles, CG 4 cycles (exits at counter 3), CY 3 cycles, back to HG.
REQ-034 reset, then no inputs for 40 cycles -> state=HG throughout, counter reaches 15 and holds, H_G=1, C_R=1.
REQ-035 car_sensor=1 until CG counter=1, then 0 -> CY entered on the next edge (CG lasted 2 cycles), then HG after 3 cycles.
REQ-036 single-cycle ped_req at HG counter=2, car_sensor=0 -> HY at counter 5+1, then PW with walk=1 for 5 cycles, then HG with ped_pending=0.
REQ-037 ped_req pulse and car_sensor=1 together in HG -> HY, PW (5 cycles), HG for 6 cycles, HY, CG; a ped_req issued during PW produces no second PW.
REQ-038 reset=1 for one edge during CG counter=2 -> next edge state=HG, counter=0, lamps H_G/C_R, ped_pending=0; with TRAFFIC_PED_EN undefined, a repeat of REQ-036 stimulus never reaches PW and walk stays 0.
